// File: rtl/cfifo_sync_ctrl.sv
// Clocked N-stage relay FIFO controller: bubble-pipeline occupancy with per-stage
// fire pulses, a programmable departure delay line, hold/flush and status outputs.

module cfifo_sync_stage (
  input  logic clk,
  input  logic rst,
  input  logic i_in,
  input  logic i_out,
  input  logic i_flush,
  output logic o_v,
  output logic o_f
);
  logic r_v, r_f, w_nxt;

  assign w_nxt = !i_flush & (i_in | (r_v & !i_out));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= 1'b0;
      r_f <= 1'b0;
    end else begin
      r_v <= w_nxt;
      r_f <= w_nxt & !r_v;
    end
  end

  assign o_v = r_v;
  assign o_f = r_f;
endmodule

module cfifo_sync_ctrl #(
  parameter  int RELAY_NUMS = 5,
  parameter  int OUT_DELAY  = 2,
  localparam int CNT_W      = $clog2(RELAY_NUMS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_drive,
  output logic                  o_free,
  input  logic                  i_freeNext,
  output logic                  o_driveNext,
  output logic [RELAY_NUMS-1:0] o_fire_n,
  input  logic                  i_hold,
  input  logic                  i_flush,
  output logic [CNT_W-1:0]      o_count,
  output logic                  o_full,
  output logic                  o_empty
);
  logic [RELAY_NUMS-1:0] w_v, w_f, w_in, w_out;
  logic [OUT_DELAY-1:0]  r_dly, w_dly_nxt;
  logic                  w_depart;
  logic [CNT_W-1:0]      w_count;

  assign o_free   = !w_v[0] & !i_hold & !i_flush & !rst;
  assign w_depart = w_v[RELAY_NUMS-1] & i_freeNext & !i_hold & !i_flush;
  assign w_in[0]  = i_drive & o_free;

  // Moves look only at pre-edge occupancy, so a token advances at most one stage per edge.
  for (genvar k = 0; k < RELAY_NUMS; k++) begin : g_stage
    if (k == RELAY_NUMS - 1) begin : g_last
      assign w_out[k] = w_depart;
    end else begin : g_mid
      assign w_out[k]   = w_v[k] & !w_v[k+1] & !i_hold & !i_flush;
      assign w_in[k+1]  = w_out[k];
    end
    cfifo_sync_stage u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_in    (w_in[k]),
      .i_out   (w_out[k]),
      .i_flush (i_flush),
      .o_v     (w_v[k]),
      .o_f     (w_f[k])
    );
  end

  if (OUT_DELAY == 1) begin : g_d1
    assign w_dly_nxt = w_depart;
  end else begin : g_dn
    assign w_dly_nxt = {r_dly[OUT_DELAY-2:0], w_depart};
  end

  // Delay line keeps shifting through hold and flush; only reset discards it.
  always_ff @(posedge clk) begin
    if (rst) r_dly <= '0;
    else     r_dly <= w_dly_nxt;
  end

  always_comb begin
    w_count = '0;
    for (int k = 0; k < RELAY_NUMS; k++) w_count = w_count + CNT_W'(w_v[k]);
  end

  assign o_driveNext = r_dly[OUT_DELAY-1] & !rst;
  assign o_fire_n    = w_f;
  assign o_count     = w_count;
  assign o_full      = &w_v;
  assign o_empty     = (w_v == '0) & (r_dly == '0);
endmodule

// File: tb/tb_cfifo_sync_ctrl.sv
// Directed bench for cfifo_sync_ctrl: expected fire/driveNext events go into queues
// and a forked negedge monitor matches them against what the DUT emits.

module tb_cfifo_sync_ctrl;
  logic clk = 1'b0;
  logic rst, drive, freeNext, hold, flush;
  logic free, driveNext, full, empty;
  logic [4:0] fire;
  logic [2:0] count;
  logic c_drive, c_freeNext;
  logic c_free, c_driveNext, c_full, c_empty;
  logic [0:0] c_fire, c_count;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct { int c; logic [4:0] v; } fire_t;
  fire_t fq[$];
  int    dq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cfifo_sync_ctrl #(.RELAY_NUMS(5), .OUT_DELAY(2)) dut (
    .clk(clk), .rst(rst), .i_drive(drive), .o_free(free), .i_freeNext(freeNext),
    .o_driveNext(driveNext), .o_fire_n(fire), .i_hold(hold), .i_flush(flush),
    .o_count(count), .o_full(full), .o_empty(empty)
  );

  cfifo_sync_ctrl #(.RELAY_NUMS(1), .OUT_DELAY(1)) dut1 (
    .clk(clk), .rst(rst), .i_drive(c_drive), .o_free(c_free), .i_freeNext(c_freeNext),
    .o_driveNext(c_driveNext), .o_fire_n(c_fire), .i_hold(1'b0), .i_flush(1'b0),
    .o_count(c_count), .o_full(c_full), .o_empty(c_empty)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic pf(input int c, input logic [4:0] v);
    fire_t e;
    e.c = c;
    e.v = v;
    fq.push_back(e);
  endtask

  // Fill from empty with the consumer stalled; pipeline is full on return (t+9).
  task automatic fill;
    int t;
    t = cyc;
    drive = 1'b1; freeNext = 1'b0;
    pf(t+1, 5'b00001); pf(t+2, 5'b00010); pf(t+3, 5'b00101);
    pf(t+4, 5'b01010); pf(t+5, 5'b10101); pf(t+6, 5'b01010);
    pf(t+7, 5'b00101); pf(t+8, 5'b00010); pf(t+9, 5'b00001);
    repeat (9) step;
  endtask

  // Three accepts with consumer ready; returns in t+6 with v=01010 and one token in d.
  task automatic launch3(input bit exp_pulse);
    int t;
    t = cyc;
    drive = 1'b1; freeNext = 1'b1;
    pf(t+1, 5'b00001); pf(t+2, 5'b00010); pf(t+3, 5'b00101);
    pf(t+4, 5'b01010); pf(t+5, 5'b10101); pf(t+6, 5'b01010);
    if (exp_pulse) dq.push_back(t+7);
    repeat (5) step;
    drive = 1'b0;
    step;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1);
  end

  initial begin
    int t0, e;
    rst = 1'b1; drive = 1'b0; freeNext = 1'b0; hold = 1'b0; flush = 1'b0;
    c_drive = 1'b0; c_freeNext = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (fire !== 5'b0) begin
          if (fq.size() == 0) chk("fire_unexpected", {27'b0, fire}, 32'h0);
          else begin
            fire_t x;
            x = fq.pop_front();
            chk("fire_cyc", cyc, x.c);
            chk("fire_vec", {27'b0, fire}, {27'b0, x.v});
          end
        end
        if (driveNext !== 1'b0) begin
          if (dq.size() == 0) chk("drv_unexpected", {31'b0, driveNext}, 32'h0);
          else chk("drv_cyc", cyc, dq.pop_front());
        end
      end
    join_none

    // Reset
    step;
    @(negedge clk);
    chk("rst_free", free, 0);
    chk("rst_drv", driveNext, 0);
    step;
    rst = 1'b0;
    @(negedge clk);
    chk("rel_free", free, 1);
    chk("rel_fire", fire, 0);
    chk("rel_count", count, 0);
    chk("rel_full", full, 0);
    chk("rel_empty", empty, 1);
    chk("rel_drv", driveNext, 0);

    // Single token
    step;
    t0 = cyc; drive = 1'b1; freeNext = 1'b1;
    for (int k = 0; k < 5; k++) pf(t0+1+k, 5'(1 << k));
    dq.push_back(t0+7);
    step;
    drive = 1'b0;
    @(negedge clk);
    chk("single_free_busy", free, 0);
    chk("single_count1", count, 1);
    repeat (5) step;
    @(negedge clk);
    chk("single_empty_dpend", empty, 0);
    chk("single_count0", count, 0);
    repeat (2) step;
    @(negedge clk);
    chk("single_empty", empty, 1);

    // Backpressure fill then drain
    step;
    fill;
    @(negedge clk);
    chk("bp_count", count, 5);
    chk("bp_full", full, 1);
    chk("bp_free", free, 0);
    step;
    @(negedge clk);
    chk("bp_still_full", count, 5);
    step;
    e = cyc; drive = 1'b0; freeNext = 1'b1;
    for (int k = 1; k <= 5; k++) dq.push_back(e + 2*k);
    pf(e+2, 5'b10000); pf(e+3, 5'b01000); pf(e+4, 5'b10100); pf(e+5, 5'b01010);
    pf(e+6, 5'b10100); pf(e+7, 5'b01000); pf(e+8, 5'b10000);
    repeat (9) step;
    @(negedge clk);
    chk("drain_count", count, 0);
    repeat (2) step;
    @(negedge clk);
    chk("drain_empty", empty, 1);
    chk("drain_fq", fq.size(), 0);
    chk("drain_dq", dq.size(), 0);

    // Hold with a departure already in the delay line
    step;
    t0 = cyc;
    launch3(1'b1);
    hold = 1'b1;
    @(negedge clk);
    chk("hold_free", free, 0);
    step;
    @(negedge clk);
    chk("hold_count_a", count, 2);
    repeat (2) step;
    @(negedge clk);
    chk("hold_count_b", count, 2);
    chk("hold_free_b", free, 0);
    step;
    hold = 1'b0;
    pf(t0+11, 5'b10100); pf(t0+12, 5'b01000); pf(t0+13, 5'b10000);
    dq.push_back(t0+13); dq.push_back(t0+15);
    @(negedge clk);
    chk("hold_rel_free", free, 1);
    repeat (6) step;
    @(negedge clk);
    chk("hold_empty", empty, 1);

    // Flush collision with a pending departure
    step;
    fill;
    step;
    e = cyc; drive = 1'b0; freeNext = 1'b1;
    step;
    flush = 1'b1; drive = 1'b1;
    dq.push_back(e+2);
    @(negedge clk);
    chk("flush_pre_count", count, 4);
    chk("flush_free", free, 0);
    step;
    flush = 1'b0; drive = 1'b0; freeNext = 1'b0;
    @(negedge clk);
    chk("flush_count", count, 0);
    chk("flush_empty_dpend", empty, 0);
    step;
    @(negedge clk);
    chk("flush_empty", empty, 1);

    // Reset mid-operation: two tokens in stages, one about to leave d
    step;
    t0 = cyc;
    launch3(1'b0);
    step;
    pf(t0+7, 5'b10100);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_drv_gated", driveNext, 0);
    chk("mrst_free", free, 0);
    step;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_free_rel", free, 1);
    chk("mrst_count", count, 0);
    chk("mrst_full", full, 0);
    chk("mrst_empty", empty, 1);
    chk("mrst_fire", fire, 0);
    repeat (4) step;

    // N=1, D=1 corner
    step;
    c_drive = 1'b1; c_freeNext = 1'b1;
    @(negedge clk);
    chk("c_free0", c_free, 1);
    step;
    @(negedge clk);
    chk("c_fire1", c_fire, 1);
    chk("c_full1", c_full, 1);
    chk("c_count1", c_count, 1);
    chk("c_free1", c_free, 0);
    step;
    @(negedge clk);
    chk("c_drv2", c_driveNext, 1);
    chk("c_free2", c_free, 1);
    chk("c_fire2", c_fire, 0);
    step;
    c_drive = 1'b0;
    @(negedge clk);
    chk("c_fire3", c_fire, 1);
    chk("c_drv3", c_driveNext, 0);
    step;
    @(negedge clk);
    chk("c_drv4", c_driveNext, 1);
    step;
    @(negedge clk);
    chk("c_empty5", c_empty, 1);

    repeat (3) step;
    chk("end_fq", fq.size(), 0);
    chk("end_dq", dq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cfifo_sync_ctrl.md
# cfifo_sync_ctrl

Synchronous, parametrised successor to the N-relay FIFO controller. It models the token pipeline as RELAY_NUMS occupancy stages and emits a one-cycle fire pulse per stage when a token lands, using the same drive/free handshake on both ends. It adds a programmable output delay line, hold and flush modes, and occupancy/status outputs. It sits between a token source (drive/free) and a downstream consumer (driveNext/freeNext) in clocked subsystems.

## Interface
- RELAY_NUMS, default 5: number of pipeline stages; legal range 1..32.
- OUT_DELAY, default 2: cycles from last-stage departure to o_driveNext; legal range 1..8.
- CNT_W, derived: $clog2(RELAY_NUMS+1); not overridable.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_drive  in  1  upstream offers a token (level; accepted when o_free=1 in the same cycle).
- o_free  out  1  stage 0 can accept a token this cycle.
- i_freeNext  in  1  downstream accepts the last-stage token this cycle (level).
- o_driveNext  out  1  one-cycle pulse, OUT_DELAY cycles after each departure.
- o_fire_n  out  RELAY_NUMS  bit k pulses for one cycle when a token enters stage k.
- i_hold  in  1  freeze: no accept, no advance, no departure.
- i_flush  in  1  discard all tokens held in the stages.
- o_count  out  CNT_W  number of occupied stages.
- o_full  out  1  all stages occupied.
- o_empty  out  1  no stage occupied and delay line idle.

## Operation
- State: occupancy vector v[RELAY_NUMS-1:0], fire register f[RELAY_NUMS-1:0], and OUT_DELAY-bit shift register d.
- Accept: if i_drive & o_free, then v[0] is set at the next edge.
- o_free = !v[0] & !i_hold & !i_flush & !rst (combinational).
- Advance: a token moves from stage k to stage k+1 at an edge when v[k] & !v[k+1] were both true in the pre-edge state. There is no same-cycle ripple: bubble pipeline, at most one token per 2 cycles per stage.
- Depart: if v[N-1] & i_freeNext & !i_hold, then v[N-1] clears and d[0] is set at the edge. A token entering the last stage in that same edge is still allowed, because it uses the pre-edge state.
- Fire: f[k] is set at exactly the edges where v[k] goes 0->1; otherwise f[k] is 0. o_fire_n = f.
- Delay line: d shifts every cycle, including during hold and flush. o_driveNext = d[OUT_DELAY-1]. Back-to-back departures each produce their own pulse.
- i_hold: v and f are frozen (f forced to 0); d keeps shifting.
- i_flush has priority over i_hold and i_drive. At the next edge: v=0, f=0, no accept, no departure. Tokens already in d still produce o_driveNext.
- Status outputs, all combinational from registered state:
  - o_count = popcount(v).
  - o_full = &v.
  - o_empty = (v==0) & (d==0).
- rst: v, f and d are cleared at the edge. While rst=1: o_free=0 and o_driveNext=0.
- After reset release, every output holds its reset value: o_fire_n=0, o_driveNext=0, o_count=0, o_full=0, o_empty=1. o_free=1 unless i_hold or i_flush is asserted.

## Timing
- Accept latency: i_drive & o_free in cycle c gives o_fire_n[0]=1 in cycle c+1.
- Empty-path propagation: o_fire_n[k]=1 in cycle c+1+k.
- Departure: i_freeNext=1 with v[N-1]=1 in cycle e gives o_driveNext=1 in cycle e+OUT_DELAY, for exactly 1 cycle.
- Sustained throughput, both ends unstalled: one token per 2 cycles.
- Full pipeline, drain after i_freeNext rises: departures at e, e+2, e+4, ... (the vacated last stage refills one cycle after each departure).
- Reset is effective at the first edge with rst=1, and takes effect mid-operation too: any token in d is lost and produces no pulse.

## Test plan
- Single token (N=5, D=2): i_drive=1 in cycle 0 only, i_freeNext=1 throughout -> o_fire_n[0..4] in cycles 1..5, o_driveNext in cycle 7; o_count returns to 0 and o_empty=1 from cycle 8.
- Backpressure fill: i_freeNext=0, i_drive=1 continuously -> o_count reaches 5, o_full=1, o_free=0. Then raise i_freeNext at cycle e -> o_driveNext at e+2, e+4, e+6, e+8, e+10; finally o_count=0.
- Hold: 3 tokens in flight, i_hold=1 for 4 cycles -> no o_fire_n pulses, o_free=0, o_count unchanged; a pulse already in d still emerges on schedule; propagation resumes one stage per cycle after release.
- Flush collision: o_count=4, i_flush=1 with i_drive=1 and i_freeNext=1 in the same cycle, with one departure pending in d -> o_count=0 next cycle, no acceptance, no new departure, and the pending o_driveNext is still emitted.
- Reset mid-operation: 2 tokens in stages plus 1 in d, rst=1 for 1 cycle -> next cycle all outputs at reset values, no o_driveNext ever appears, and o_free=1 after release.
- Corner configuration N=1, D=1: drive in cycle 0 -> o_fire_n[0] in cycle 1; with i_freeNext=1, o_driveNext in cycle 2; the next accept is possible in cycle 2.
